regfile_alu_engine: RTL

Parametrised successor to the 16x16 register-file-plus-ALU datapath. It couples a DEPTH x WIDTH register file with an ALU through a valid/ready command port and a small controller FSM. Multi-cycle ops (shift-add multiply), a persistent flags register and a debug read port are new. It sits between the switch/GPIO command source and the matrix/7-seg display logic, which reads registers through the debug port.

---
 rtl/regfile_alu_engine_pkg.sv | 49 ++++
 rtl/regfile_alu_engine_alu_core.sv | 104 ++++++++++
 rtl/regfile_alu_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/regfile_alu_engine_pkg.sv
// ---------------------------------------------------------------------------
// regfile_alu_engine_pkg
// Shared definitions for the register-file + ALU engine:
//   - opcode encodings OP_PASSA .. OP_CMP (14/15 are reserved)
//   - flag bit positions inside the 4-bit {V,C,N,Z} flag word
//   - controller FSM state encoding (also driven out on dbg_state)
//   - make_flags helper that packs individual flag bits into a flag word
// ---------------------------------------------------------------------------
package regfile_alu_engine_pkg;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_ADDC  = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOTA  = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_LOADI = 4'd12;
  localparam logic [3:0] OP_CMP   = 4'd13;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic logic [3:0] make_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f = 4'b0000;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/regfile_alu_engine_alu_core.sv
// ---------------------------------------------------------------------------
// regfile_alu_engine_alu_core
// Purely combinational ALU for every single-cycle opcode.
// Ports:
//   op       in  4      opcode
//   a, b     in  WIDTH  operands (b is already the imm/register selection)
//   cin      in  1      carry-in, only honoured by ADDC
//   result   out WIDTH  truncated result
//   flags    out 4      {V,C,N,Z} computed from result
//   wr_en    out 1      op writes its result to the destination register
//   flags_en out 1      op updates the persistent flag register
// MUL and the reserved opcodes report wr_en=0/flags_en=0 here; MUL is
// carried out by the iterative multiplier in the top level.
// ---------------------------------------------------------------------------
module regfile_alu_engine_alu_core
  import regfile_alu_engine_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             wr_en,
  output logic             flags_en
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]       shamt;
  logic                carry_in;
  logic [WIDTH:0]      add_w;
  logic [WIDTH:0]      sub_w;
  logic [WIDTH:0]      shl_w;
  logic [WIDTH:0]      shr_w;
  logic signed [WIDTH:0] a_ext;
  logic [WIDTH:0]      sra_w;
  logic                ovf_add;
  logic                ovf_sub;
  logic                c;
  logic                v;

  assign shamt    = b[SW-1:0];
  assign carry_in = (op == OP_ADDC) & cin;

  // One extra bit on each adder/shifter catches the carry / last bit out.
  assign add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;
  assign a_ext = {a, 1'b0};
  assign sra_w = a_ext >>> shamt;

  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) & (add_w[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) & (sub_w[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    c        = 1'b0;
    v        = 1'b0;
    wr_en    = 1'b1;
    flags_en = 1'b1;
    case (op)
      OP_PASSA: result = a;
      OP_ADD, OP_ADDC: begin
        result = add_w[WIDTH-1:0];
        c      = add_w[WIDTH];
        v      = ovf_add;
      end
      OP_SUB, OP_CMP: begin
        result = sub_w[WIDTH-1:0];
        c      = ~sub_w[WIDTH];  // no-borrow: a >= b unsigned
        v      = ovf_sub;
        wr_en  = (op == OP_SUB);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOTA:  result = ~a;
      OP_SHL: begin
        result = shl_w[WIDTH-1:0];
        c      = shl_w[WIDTH];
      end
      OP_SHR: begin
        result = shr_w[WIDTH:1];
        c      = shr_w[0];
      end
      OP_SRA: begin
        result = sra_w[WIDTH:1];
        c      = sra_w[0];
      end
      OP_LOADI: result = b;
      default: begin
        // MUL (handled by the top-level iterator) and reserved opcodes
        wr_en    = 1'b0;
        flags_en = 1'b0;
      end
    endcase
    flags = make_flags(v, c, result[WIDTH-1], result == '0);
  end

endmodule

// File: rtl/regfile_alu_engine.sv
// ---------------------------------------------------------------------------
// regfile_alu_engine
// DEPTH x WIDTH register file coupled to an ALU through a command port and a
// four-state controller (IDLE -> EXEC -> [MUL] -> RESP -> IDLE).
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready   command handshake
//   cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, cmd_use_imm, cmd_cin
//                           command fields, sampled on the accepting edge
//   rsp_valid               one-cycle completion pulse
//   rsp_result, rsp_flags   result and {V,C,N,Z} of the completed op
//   dbg_addr / dbg_data     combinational register read for the display side
//   dbg_state               current controller state
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE; while it is 0 the
// source must keep cmd_valid (and the fields) stable, nothing is consumed.
// Exactly one command is in flight, so there is no read-after-write hazard.
// ---------------------------------------------------------------------------
module regfile_alu_engine
  import regfile_alu_engine_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_srca,
  input  logic [AW-1:0]    cmd_srcb,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             cmd_use_imm,
  input  logic             cmd_cin,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [3:0]       flags_q;

  logic [3:0]       op_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [WIDTH-1:0] prod_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] mul_next;
  logic             dst_blocked;

  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             alu_wr_en;
  logic             alu_flags_en;

  // Register 0 reads as zero when ZERO_R0 is set, on every read path.
  assign rd_a     = (ZERO_R0 != 0 && cmd_srca == '0) ? '0 : regs[cmd_srca];
  assign rd_b     = (ZERO_R0 != 0 && cmd_srcb == '0) ? '0 : regs[cmd_srcb];
  assign dbg_data = (ZERO_R0 != 0 && dbg_addr == '0) ? '0 : regs[dbg_addr];

  assign dst_blocked = (ZERO_R0 != 0) && (dst_q == '0);

  assign cmd_ready = (state == S_IDLE);
  assign dbg_state = state;

  // Shift-add step: a_q is the shifted multiplicand, b_q the shifted
  // multiplier; the LSB of b_q decides whether a_q is accumulated.
  assign mul_next = prod_q + (b_q[0] ? a_q : '0);

  regfile_alu_engine_alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .cin      (cin_q),
    .result   (alu_result),
    .flags    (alu_flags),
    .wr_en    (alu_wr_en),
    .flags_en (alu_flags_en)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      flags_q    <= '0;
      op_q       <= '0;
      dst_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      prod_q     <= '0;
      cnt_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            dst_q <= cmd_dst;
            a_q   <= rd_a;
            b_q   <= cmd_use_imm ? cmd_imm : rd_b;
            cin_q <= cmd_cin;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            prod_q <= '0;
            cnt_q  <= CW'(WIDTH);
            state  <= S_MUL;
          end else begin
            if (alu_wr_en && !dst_blocked) begin
              regs[dst_q] <= alu_result;
            end
            if (alu_flags_en) begin
              flags_q   <= alu_flags;
              rsp_flags <= alu_flags;
            end else begin
              rsp_flags <= flags_q;
            end
            rsp_result <= alu_result;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_MUL: begin
          prod_q <= mul_next;
          a_q    <= a_q << 1;
          b_q    <= b_q >> 1;
          cnt_q  <= cnt_q - CW'(1);
          // The last step writes mul_next directly, so the product lands
          // on the same edge that raises rsp_valid.
          if (cnt_q == CW'(1)) begin
            if (!dst_blocked) begin
              regs[dst_q] <= mul_next;
            end
            flags_q    <= make_flags(1'b0, 1'b0, mul_next[WIDTH-1], mul_next == '0);
            rsp_flags  <= make_flags(1'b0, 1'b0, mul_next[WIDTH-1], mul_next == '0);
            rsp_result <= mul_next;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
